uart_rx_deserializer: RTL and testbench



---
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling FSM and a one-entry
// valid/ready output buffer with framing-error and overrun pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned DATA_BITS   = 8
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_p,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned ClksPerBit = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit);
  localparam int unsigned IdxW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] HalfLoad = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(ClksPerBit - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   rxd_s;
  logic                   issue;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge CLK100MHZ or posedge rst_p) begin
    if (rst_p) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

  always_ff @(posedge CLK100MHZ or posedge rst_p) begin
    if (rst_p) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    issue       = 1'b0;

    if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (!rxd_s) begin
          cnt_d   = HalfLoad;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rxd_s) begin
            idx_d   = '0;
            cnt_d   = BitLoad;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s;
          cnt_d          = BitLoad;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStop: begin
        // Return to idle mid-stop-bit so back-to-back frames are not lost.
        if (cnt_q == '0) begin
          if (rxd_s) begin
            issue   = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWaitIdle: begin
        if (rxd_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: serial frames driven at the pin,
// outputs compared against hand-computed values.
module tb_uart_rx_deserializer;

  localparam int BitClks = 868;

  logic       clk;
  logic       rst_p;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] rise_data[$];
  int         rise_cyc[$];

  uart_rx_deserializer #(
    .CLK_FREQ_HZ(100_000_000),
    .BAUD_RATE  (115200),
    .DATA_BITS  (8)
  ) u_dut (
    .CLK100MHZ(clk),
    .rst_p    (rst_p),
    .uart_rxd (uart_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_data.push_back(rx_data);
      rise_cyc.push_back(cyc);
    end
    if (rx_valid)  valid_cyc <= valid_cyc + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    prev_valid <= rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the first nbits of {stop, data, start}; call at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits,
                            input int bclks);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uart_rxd = fr[i];
      repeat (bclks) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    int n0;
    int fe0;
    int ov0;
    int vc0;

    rst_p    = 1'b1;
    uart_rxd = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_p = 1'b0;
    @(negedge clk);

    check_eq("reset_valid", rx_valid, 0);
    check_eq("reset_data", rx_data, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_overrun", overrun, 0);
    idle(20);

    // Single byte: valid appears on the 8249th posedge after the pin falls
    // (2 synchronizer edges + 8247 cycles from T).
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 10, BitClks);
      begin
        while (!rx_valid && n < 10000) begin
          @(posedge clk);
          n++;
          @(negedge clk);
        end
      end
    join
    check_eq("a5_latency", n, 8249);
    check_eq("a5_data", rx_data, 8'hA5);
    idle(500);
    check_eq("a5_hold_valid", rx_valid, 1);
    consume();
    check_eq("a5_drain_valid", rx_valid, 0);
    check_eq("a5_drain_data", rx_data, 8'hA5);
    check_eq("a5_frame_err", fe_cnt, 0);
    check_eq("a5_overrun", ov_cnt, 0);

    // Start glitch shorter than half a bit.
    n0 = rise_data.size();
    uart_rxd = 1'b0;
    repeat (200) @(negedge clk);
    idle(2000);
    check_eq("glitch_no_valid", rise_data.size(), n0);
    check_eq("glitch_no_frame_err", fe_cnt, 0);
    send_frame(8'h3C, 1'b1, 10, BitClks);
    idle(200);
    check_eq("glitch_next_valid", rx_valid, 1);
    check_eq("glitch_next_data", rx_data, 8'h3C);
    consume();

    // Framing error followed by a break.
    idle(200);
    send_frame(8'h3C, 1'b0, 10, BitClks);
    uart_rxd = 1'b0;
    repeat (2000) @(negedge clk);
    check_eq("break_frame_err_cnt", fe_cnt, 1);
    check_eq("break_valid", rx_valid, 0);
    idle(1000);
    check_eq("break_no_extra_err", fe_cnt, 1);
    send_frame(8'h55, 1'b1, 10, BitClks);
    idle(200);
    check_eq("after_break_valid", rx_valid, 1);
    check_eq("after_break_data", rx_data, 8'h55);
    consume();

    // Overrun: two back-to-back frames without consuming.
    idle(200);
    send_frame(8'h11, 1'b1, 10, BitClks);
    send_frame(8'h22, 1'b1, 10, BitClks);
    idle(200);
    check_eq("overrun_data", rx_data, 8'h11);
    check_eq("overrun_valid", rx_valid, 1);
    check_eq("overrun_cnt", ov_cnt, 1);
    consume();
    check_eq("overrun_drained", rx_valid, 0);

    // Streaming with the consumer always ready.
    idle(200);
    rx_ready = 1'b1;
    n0 = rise_data.size();
    vc0 = valid_cyc;
    send_frame(8'h00, 1'b1, 10, BitClks);
    send_frame(8'hFF, 1'b1, 10, BitClks);
    idle(500);
    rx_ready = 1'b0;
    check_eq("stream_words", rise_data.size() - n0, 2);
    check_eq("stream_valid_cycles", valid_cyc - vc0, 2);
    if (rise_data.size() - n0 == 2) begin
      check_eq("stream_data0", rise_data[n0], 8'h00);
      check_eq("stream_data1", rise_data[n0+1], 8'hFF);
      check_eq("stream_spacing", rise_cyc[n0+1] - rise_cyc[n0], 8680);
    end

    // +2% slow baud still received.
    send_frame(8'h96, 1'b1, 10, 885);
    idle(200);
    check_eq("slow_baud_valid", rx_valid, 1);
    check_eq("slow_baud_data", rx_data, 8'h96);

    // Reset during data bit 3 with a word still buffered.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h77, 1'b1, 4, BitClks);
    uart_rxd = 1'b0;
    repeat (400) @(negedge clk);
    rst_p = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("midrst_valid", rx_valid, 0);
    check_eq("midrst_data", rx_data, 0);
    rst_p    = 1'b0;
    uart_rxd = 1'b1;
    idle(2000);
    check_eq("midrst_idle_valid", rx_valid, 0);
    send_frame(8'h5A, 1'b1, 10, BitClks);
    idle(200);
    check_eq("midrst_5a_valid", rx_valid, 1);
    check_eq("midrst_5a_data", rx_data, 8'h5A);
    check_eq("midrst_no_frame_err", fe_cnt, fe0);
    check_eq("midrst_no_overrun", ov_cnt, ov0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
